// File: rtl/cpu_pkg.sv
// Shared definitions for the exp5 accumulator CPU sequencer.
//  - opcode values OP_CLA..OP_BAN (opcode field is 8 bits wide)
//  - bit positions of the opcode and operand fields in the 16-bit instruction
//  - sequencer state encoding
package cpu_pkg;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 8;
  localparam int OPR_MSB = 7;
  localparam int OPR_LSB = 0;

  localparam logic [7:0] OP_CLA = 8'd0;
  localparam logic [7:0] OP_COM = 8'd1;
  localparam logic [7:0] OP_SHR = 8'd2;
  localparam logic [7:0] OP_CSL = 8'd3;
  localparam logic [7:0] OP_STP = 8'd4;
  localparam logic [7:0] OP_ADD = 8'd5;
  localparam logic [7:0] OP_STA = 8'd6;
  localparam logic [7:0] OP_LDA = 8'd7;
  localparam logic [7:0] OP_JMP = 8'd8;
  localparam logic [7:0] OP_BAN = 8'd9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    MEM    = 3'd3,
    EXEC   = 3'd4,
    HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction classifier.
// Ports:
//  ir          in  16  latched instruction register
//  needs_mem   out 1   LDA/ADD: a data-memory read precedes execution
//  is_branch   out 1   JMP/BAN
//  is_store    out 1   STA
//  is_halt     out 1   STP
//  is_illegal  out 1   opcode outside 0..9 (also any unknown opcode)
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic        needs_mem,
  output logic        is_branch,
  output logic        is_store,
  output logic        is_halt,
  output logic        is_illegal
);

  always_comb begin
    needs_mem  = 1'b0;
    is_branch  = 1'b0;
    is_store   = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    // An opcode that matches no item (including one carrying x bits)
    // lands in default and is flagged illegal.
    case (ir[OPC_MSB:OPC_LSB])
      OP_CLA, OP_COM, OP_SHR, OP_CSL: begin
      end
      OP_STP:         is_halt   = 1'b1;
      OP_ADD, OP_LDA: needs_mem = 1'b1;
      OP_STA:         is_store  = 1'b1;
      OP_JMP, OP_BAN: is_branch = 1'b1;
      default:        is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Fetch/decode/execute sequencer for the exp5 accumulator CPU.
// Ports:
//  clk, rst_n   clock, asynchronous active-low reset
//  start        level; leaves IDLE/HALT and fetches from PC=0, ignored elsewhere
//  ins_addr     instruction address (= PC) into combinational instruction memory
//  ins          instruction word {opcode[15:8], operand[7:0]}
//  acc_neg      accumulator sign, sampled in EXEC by BAN
//  alu_op       opcode of the executing instruction, valid with acc_we
//  acc_we       1-cycle strobe, accumulator loads ALU result
//  dmem_addr    data address = IR operand
//  dmem_re      1-cycle data read strobe (LDA/ADD), data valid the cycle after
//  dmem_we      1-cycle data write strobe (STA)
//  halted       high while in HALT
//  illegal      sticky illegal-opcode flag, cleared only by reset
//  pc_dbg       current PC
//  state_dbg    current sequencer state
// There is no valid/ready handshake: start is a plain level and every strobe
// is a registered single-cycle pulse with no back-pressure.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W    = 7,
  parameter int DADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [PC_W-1:0]    ins_addr,
  input  logic [15:0]        ins,
  input  logic               acc_neg,
  output logic [3:0]         alu_op,
  output logic               acc_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic               dmem_re,
  output logic               dmem_we,
  output logic               halted,
  output logic               illegal,
  output logic [PC_W-1:0]    pc_dbg,
  output state_t             state_dbg
);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;

  logic needs_mem, is_branch, is_store, is_halt, is_illegal;
  logic is_acc_op;
  logic take_branch;

  cpu_decode u_decode (
    .ir         (ir),
    .needs_mem  (needs_mem),
    .is_branch  (is_branch),
    .is_store   (is_store),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // Register-only ALU instructions: everything that is not one of the other classes.
  assign is_acc_op = ~(needs_mem | is_branch | is_store | is_halt | is_illegal);

  // JMP always redirects; BAN only on a negative accumulator.
  assign take_branch = is_branch &
                       ((ir[OPC_MSB:OPC_LSB] != OP_BAN) | acc_neg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = FETCH;
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        if (is_halt || is_illegal) state_nxt = HALT;
        else if (needs_mem)        state_nxt = MEM;
        else                       state_nxt = EXEC;
      end
      MEM:    state_nxt = EXEC;
      EXEC:   state_nxt = FETCH;
      HALT:   if (start) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // PC, IR and registered strobes. Strobes are computed one state ahead so
  // they are high exactly during the MEM/EXEC cycle they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= '0;
      ir        <= '0;
      alu_op    <= '0;
      dmem_addr <= '0;
      acc_we    <= 1'b0;
      dmem_re   <= 1'b0;
      dmem_we   <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      acc_we  <= 1'b0;
      dmem_re <= 1'b0;
      dmem_we <= 1'b0;
      case (state)
        IDLE, HALT: if (start) pc <= '0;
        FETCH: begin
          ir <= ins;
          pc <= pc + PC_W'(1);
        end
        DECODE: begin
          alu_op    <= ir[OPC_LSB +: 4];
          dmem_addr <= ir[OPR_LSB +: DADDR_W];
          if (is_illegal) illegal <= 1'b1;
          acc_we  <= is_acc_op;
          dmem_re <= needs_mem;
          dmem_we <= is_store;
        end
        MEM:  acc_we <= 1'b1;
        // Overrides the increment done in FETCH.
        EXEC: if (take_branch) pc <= ir[OPR_LSB +: PC_W];
        default: begin
        end
      endcase
    end
  end

  assign ins_addr  = pc;
  assign pc_dbg    = pc;
  assign halted    = (state == HALT);
  assign state_dbg = state;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
module tb_cpu_seq_ctrl;
  import cpu_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  ins_addr;
  logic [15:0] ins;
  logic        acc_neg;
  logic [3:0]  alu_op;
  logic        acc_we;
  logic [7:0]  dmem_addr;
  logic        dmem_re;
  logic        dmem_we;
  logic        halted;
  logic        illegal;
  logic [6:0]  pc_dbg;
  state_t      state_dbg;

  always #5 clk = ~clk;

  logic [15:0] rom [128];
  assign ins = rom[ins_addr];

  cpu_seq_ctrl #(.PC_W(7), .DADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ins_addr  (ins_addr),
    .ins       (ins),
    .acc_neg   (acc_neg),
    .alu_op    (alu_op),
    .acc_we    (acc_we),
    .dmem_addr (dmem_addr),
    .dmem_re   (dmem_re),
    .dmem_we   (dmem_we),
    .halted    (halted),
    .illegal   (illegal),
    .pc_dbg    (pc_dbg),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: instruction-level view of the visible registers.
  logic [3:0] m_opc;
  logic [7:0] m_opr;
  logic       m_illegal;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobes must never overlap.
  always @(negedge clk) begin
    n_cmp++;
    assert ($onehot0({acc_we, dmem_re, dmem_we})) else begin
      n_err++;
      $error("FAIL strobe_excl observed=%b expected=onehot0", {acc_we, dmem_re, dmem_we});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_acc_we"},  acc_we, 0);
    check({tag, "_re"},      dmem_re, 0);
    check({tag, "_we"},      dmem_we, 0);
    check({tag, "_halted"},  halted, 0);
    check({tag, "_illegal"}, illegal, 0);
    check({tag, "_pc"},      pc_dbg, 0);
    check({tag, "_alu_op"},  alu_op, 0);
    check({tag, "_daddr"},   dmem_addr, 0);
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst_n = 1'b0;
    step();
    check_reset("rst");
    rst_n = 1'b1;
    m_opc = '0;
    m_opr = '0;
    m_illegal = 1'b0;
  endtask

  task automatic fill_rom(input logic [15:0] v);
    for (int i = 0; i < 128; i++) rom[i] = v;
  endtask

  task automatic chk_cycle(input string tag, input bit e_acc, input bit e_re,
                           input bit e_we, input bit e_halt);
    check({tag, "_acc_we"},  acc_we, e_acc);
    check({tag, "_re"},      dmem_re, e_re);
    check({tag, "_we"},      dmem_we, e_we);
    check({tag, "_halted"},  halted, e_halt);
    check({tag, "_illegal"}, illegal, m_illegal);
    check({tag, "_alu_op"},  alu_op, m_opc);
    check({tag, "_daddr"},   dmem_addr, m_opr);
  endtask

  // Runs a program from PC=0 for at most max_instr instructions, checking every
  // cycle against the instruction-level model. neg_mode: 0/1 fixed acc_neg,
  // 2 random acc_neg and random (ignored) start pulses.
  task automatic run_prog(input string tag, input int max_instr, input int neg_mode,
                          output int n_instr, output bit did_halt);
    logic [6:0] pc;
    logic [7:0] opc, opr;
    bit         an;
    n_instr  = 0;
    did_halt = 1'b0;
    pc = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < max_instr; i++) begin
      opc = rom[pc][15:8];
      opr = rom[pc][7:0];
      an  = (neg_mode == 2) ? 1'($urandom_range(0, 1)) : (neg_mode == 1);
      acc_neg = an;
      if (neg_mode == 2) start = 1'($urandom_range(0, 1));
      n_instr++;
      // fetch cycle
      check({tag, "_fetch_addr"}, ins_addr, pc);
      check({tag, "_pc_dbg"}, pc_dbg, pc);
      chk_cycle({tag, "_c1"}, 0, 0, 0, 0);
      step();
      // decode cycle: PC already incremented
      check({tag, "_pc_inc"}, pc_dbg, 7'(pc + 7'd1));
      chk_cycle({tag, "_c2"}, 0, 0, 0, 0);
      step();
      start = 1'b0;
      m_opc = opc[3:0];
      m_opr = opr;
      if (opc > 8'd9 || opc == 8'd4) begin
        if (opc > 8'd9) m_illegal = 1'b1;
        chk_cycle({tag, "_halt"}, 0, 0, 0, 1);
        check({tag, "_halt_pc"}, pc_dbg, 7'(pc + 7'd1));
        did_halt = 1'b1;
        return;
      end
      case (opc)
        8'd5, 8'd7: begin
          chk_cycle({tag, "_mem"}, 0, 1, 0, 0);
          step();
          chk_cycle({tag, "_exec_ld"}, 1, 0, 0, 0);
          pc = pc + 7'd1;
        end
        8'd6: begin
          chk_cycle({tag, "_exec_st"}, 0, 0, 1, 0);
          pc = pc + 7'd1;
        end
        8'd8: begin
          chk_cycle({tag, "_exec_jmp"}, 0, 0, 0, 0);
          pc = opr[6:0];
        end
        8'd9: begin
          chk_cycle({tag, "_exec_ban"}, 0, 0, 0, 0);
          pc = an ? opr[6:0] : 7'(pc + 7'd1);
        end
        default: begin
          chk_cycle({tag, "_exec_reg"}, 1, 0, 0, 0);
          pc = pc + 7'd1;
        end
      endcase
      step();
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int  n;
    bit  h;
    int  r;
    logic [7:0] op;
    rst_n = 1'b0;
    start = 1'b0;
    acc_neg = 1'b0;
    m_opc = '0;
    m_opr = '0;
    m_illegal = 1'b0;
    fill_rom(16'h0400);
    step();
    step();
    check_reset("por");
    rst_n = 1'b1;
    step();
    check_reset("idle");

    // CLA, COM, STP: acc_we at cycles 3 and 6, halt at cycle 9 with PC=3
    rom[0] = 16'h0000; rom[1] = 16'h0100; rom[2] = 16'h0400;
    run_prog("t1", 10, 0, n, h);
    check("t1_halted", h, 1);
    check("t1_ninstr", n, 3);
    check("t1_pc3", pc_dbg, 3);
    do_reset();

    // LDA 0x05
    fill_rom(16'h0400);
    rom[0] = 16'h0705;
    run_prog("t2", 10, 0, n, h);
    check("t2_ninstr", n, 2);
    do_reset();

    // JMP 0x10
    rom[0] = 16'h0810;
    run_prog("t3", 10, 0, n, h);
    check("t3_ninstr", n, 2);
    check("t3_pc", pc_dbg, 7'h11);
    do_reset();

    // BAN 0x20, not taken then taken
    fill_rom(16'h0400);
    rom[0] = 16'h0920;
    run_prog("t4n", 10, 0, n, h);
    check("t4n_pc", pc_dbg, 7'h02);
    do_reset();
    run_prog("t4t", 10, 1, n, h);
    check("t4t_pc", pc_dbg, 7'h21);
    do_reset();

    // Illegal opcode 0x0C at PC=2, then restart with illegal still set
    rom[0] = 16'h0000; rom[1] = 16'h0000; rom[2] = 16'h0C00;
    run_prog("t5", 10, 0, n, h);
    check("t5_illegal", illegal, 1);
    check("t5_halted", halted, 1);
    run_prog("t5b", 10, 0, n, h);
    check("t5b_illegal", illegal, 1);
    check("t5b_ninstr", n, 3);
    do_reset();

    // PC wrap 127 -> 0
    fill_rom(16'h0400);
    rom[0] = 16'h087F; rom[127] = 16'h0000;
    run_prog("t6", 3, 0, n, h);
    check("t6_nohalt", h, 0);
    do_reset();

    // Reset during MEM aborts LDA
    rom[0] = 16'h0705;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("t7_re", dmem_re, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("t7_async");
    step();
    check("t7_no_acc", acc_we, 0);
    check_reset("t7_hold");
    rst_n = 1'b1;
    m_opc = '0;
    m_opr = '0;
    m_illegal = 1'b0;

    // Random programs
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < 128; i++) begin
        r = $urandom_range(0, 21);
        if (r >= 20)     op = 8'($urandom_range(10, 255));
        else             op = 8'(r % 10);
        if (op == 8'd4 && $urandom_range(0, 2) != 0) op = 8'd0;
        rom[i] = {op, 8'($urandom_range(0, 255))};
      end
      run_prog("rnd", 30, 2, n, h);
      if (h) run_prog("rnd_re", 30, 2, n, h);
      do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
